// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: A - B as magnitude plus sign, one digit per clock, LSD first.
// Latency N+1 edges (non-negative), 2N+1 (negative), 2 (invalid); start is only accepted in IDLE.
module bcd_serial_subtractor #(
    parameter int DIGIT_NUM = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*DIGIT_NUM-1:0] A,
    input  logic [4*DIGIT_NUM-1:0] B,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGIT_NUM-1:0] D,
    output logic                   neg,
    output logic                   invalid
);
    localparam int W  = 4 * DIGIT_NUM;
    localparam int IW = $clog2(DIGIT_NUM);

    typedef enum logic [1:0] {IDLE, RUN, NEGATE, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    opa, opb, work, work_nx;
    logic [IW-1:0]   idx;
    logic            borrow, bad, last;
    logic [3:0]      cell_a, cell_b, cell_dig;
    logic [4:0]      diff, diff_fix;
    logic            cell_bo;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGIT_NUM; i++)
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    // Shared digit cell: NEGATE reuses it as 0 - work digit to form the ten's complement.
    always_comb begin
        cell_a   = (state == NEGATE) ? 4'd0 : opa[{idx, 2'b00} +: 4];
        cell_b   = (state == NEGATE) ? work[{idx, 2'b00} +: 4] : opb[{idx, 2'b00} +: 4];
        diff     = {1'b0, cell_a} - {1'b0, cell_b} - {4'b0000, borrow};
        diff_fix = diff + 5'd10;
        cell_bo  = diff[4];
        cell_dig = cell_bo ? diff_fix[3:0] : diff[3:0];
        work_nx  = work;
        work_nx[{idx, 2'b00} +: 4] = cell_dig;
        last     = (idx == IW'(DIGIT_NUM - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (bad) state_nx = DONE;
                     else if (last) state_nx = cell_bo ? NEGATE : DONE;
            NEGATE:  if (last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // A rejected operand spends its one RUN cycle idle, so busy stays low for it.
    always_comb begin
        busy = ((state == RUN) && !bad) || (state == NEGATE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opa     <= '0;
            opb     <= '0;
            work    <= '0;
            idx     <= '0;
            borrow  <= 1'b0;
            bad     <= 1'b0;
            D       <= '0;
            neg     <= 1'b0;
            invalid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    opa    <= A;
                    opb    <= B;
                    bad    <= has_bad_digit(A) | has_bad_digit(B);
                    work   <= '0;
                    idx    <= '0;
                    borrow <= 1'b0;
                end
                RUN: if (bad) begin
                    D       <= '0;
                    neg     <= 1'b0;
                    invalid <= 1'b1;
                end else begin
                    work   <= work_nx;
                    idx    <= last ? '0 : idx + IW'(1);
                    borrow <= last ? 1'b0 : cell_bo;
                    if (last && !cell_bo) begin
                        D       <= work_nx;
                        neg     <= 1'b0;
                        invalid <= 1'b0;
                    end
                end
                NEGATE: begin
                    work   <= work_nx;
                    idx    <= last ? '0 : idx + IW'(1);
                    borrow <= last ? 1'b0 : cell_bo;
                    if (last) begin
                        D       <= work_nx;
                        neg     <= 1'b1;
                        invalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGIT_NUM = 8) with a small decimal reference sweep.
module tb_bcd_serial_subtractor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done, neg, invalid;
    logic [31:0] D;

    int n_cmp = 0;
    int n_err = 0;

    bcd_serial_subtractor #(.DIGIT_NUM(8)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .D(D), .neg(neg), .invalid(invalid)
    );

    always #5 clk = ~clk;

    // Runs one operation and reports what was observed; lat is the edge index after which done was seen.
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                            output int lat, output int bcnt, output logic [31:0] d,
                            output logic ng, output logic inv, output logic pulse1, output logic held);
        logic [31:0] d0;
        logic        n0;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = 32'h98765432; B = 32'h12345678;
        d0 = D; n0 = neg; held = 1'b1; lat = -1; bcnt = 0;
        if (busy) bcnt++;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (done) begin lat = e; break; end
            if (busy) bcnt++;
            if (D !== d0 || neg !== n0) held = 1'b0;
        end
        d = D; ng = neg; inv = invalid;
        @(posedge clk); #1;
        pulse1 = !done && !busy;
    endtask

    function automatic longint bcd2int(input logic [31:0] v);
        longint r = 0;
        for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input longint v);
        logic [31:0] r = '0;
        longint      t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, neg, invalid} !== 4'b0000 || D !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b done=%b neg=%b inv=%b D=%h, want all zero", busy, done, neg, invalid, D);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_positive;
        int lat, bcnt; logic [31:0] d; logic ng, inv, p1, held;
        drive_op(32'h00000123, 32'h00000045, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (d !== 32'h00000078) begin n_err++; $display("FAIL pos_D: got %h want 00000078", d); end
        n_cmp++; if (ng !== 1'b0 || inv !== 1'b0) begin n_err++; $display("FAIL pos_flags: neg=%b inv=%b want 0 0", ng, inv); end
        n_cmp++; if (lat != 8) begin n_err++; $display("FAIL pos_latency: done after edge %0d want 8", lat); end
        n_cmp++; if (bcnt != 8) begin n_err++; $display("FAIL pos_busy: busy %0d cycles want 8", bcnt); end
        n_cmp++; if (p1 !== 1'b1) begin n_err++; $display("FAIL pos_pulse: done/busy after DONE=%b want 1", p1); end
    endtask

    task automatic test_negative;
        int lat, bcnt; logic [31:0] d; logic ng, inv, p1, held;
        drive_op(32'h00000045, 32'h00000123, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (d !== 32'h00000078 || ng !== 1'b1) begin n_err++; $display("FAIL neg_result: D=%h neg=%b want 00000078 1", d, ng); end
        n_cmp++; if (lat != 16) begin n_err++; $display("FAIL neg_latency: done after edge %0d want 16", lat); end
        n_cmp++; if (bcnt != 16) begin n_err++; $display("FAIL neg_busy: busy %0d cycles want 16", bcnt); end
        n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL neg_hold: D/neg changed before done (held=%b) want 1", held); end
    endtask

    task automatic test_extremes;
        int lat, bcnt; logic [31:0] d; logic ng, inv, p1, held;
        drive_op(32'h99999999, 32'h99999999, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (d !== 32'h0 || ng !== 1'b0 || lat != 8) begin n_err++; $display("FAIL equal: D=%h neg=%b lat=%0d want 00000000 0 8", d, ng, lat); end
        drive_op(32'h00000000, 32'h99999999, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (d !== 32'h99999999 || ng !== 1'b1 || lat != 16) begin n_err++; $display("FAIL zero_minus_max: D=%h neg=%b lat=%0d want 99999999 1 16", d, ng, lat); end
        drive_op(32'h10000000, 32'h00000001, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (d !== 32'h09999999 || ng !== 1'b0) begin n_err++; $display("FAIL borrow_chain: D=%h neg=%b want 09999999 0", d, ng); end
        drive_op(32'h00000001, 32'h10000000, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (d !== 32'h09999999 || ng !== 1'b1) begin n_err++; $display("FAIL borrow_chain_neg: D=%h neg=%b want 09999999 1", d, ng); end
    endtask

    task automatic test_invalid;
        int lat, bcnt; logic [31:0] d; logic ng, inv, p1, held;
        drive_op(32'h0000001A, 32'h00000001, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (inv !== 1'b1 || d !== 32'h0 || ng !== 1'b0) begin n_err++; $display("FAIL inv_a: inv=%b D=%h neg=%b want 1 00000000 0", inv, d, ng); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL inv_latency: done after edge %0d want 1", lat); end
        n_cmp++; if (bcnt != 0) begin n_err++; $display("FAIL inv_busy: busy %0d cycles want 0", bcnt); end
        drive_op(32'h00000100, 32'h00000001, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (inv !== 1'b0 || d !== 32'h00000099 || ng !== 1'b0) begin n_err++; $display("FAIL inv_clear: inv=%b D=%h neg=%b want 0 00000099 0", inv, d, ng); end
        drive_op(32'h00000001, 32'hF0000000, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (inv !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL inv_b_msd: inv=%b D=%h want 1 00000000", inv, d); end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt; logic [31:0] d; logic ng, inv, p1, held;
        drive_op(32'h00000050, 32'h00000050, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (d !== 32'h0 || ng !== 1'b0) begin n_err++; $display("FAIL b2b_first: D=%h neg=%b want 00000000 0", d, ng); end
        drive_op(32'h00005000, 32'h00000001, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (d !== 32'h00004999 || ng !== 1'b0 || lat != 8) begin n_err++; $display("FAIL b2b_second: D=%h neg=%b lat=%0d want 00004999 0 8", d, ng, lat); end
    endtask

    task automatic test_abort;
        int lat, bcnt; logic [31:0] d; logic ng, inv, p1, held;
        logic saw_done = 1'b0;
        @(negedge clk);
        A = 32'h00000045; B = 32'h00000123; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            if (e == 5) start = 1'b1;
            if (e == 12) reset = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) saw_done = 1'b1;
        end
        n_cmp++;
        if ({busy, done, neg, invalid} !== 4'b0000 || D !== 32'h0) begin
            n_err++;
            $display("FAIL abort_reset: busy=%b done=%b neg=%b inv=%b D=%h want all zero", busy, done, neg, invalid, D);
        end
        reset = 1'b0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: activity=%b want 0", saw_done); end
        drive_op(32'h00000123, 32'h00000045, lat, bcnt, d, ng, inv, p1, held);
        n_cmp++; if (d !== 32'h00000078 || ng !== 1'b0 || lat != 8) begin n_err++; $display("FAIL abort_recover: D=%h neg=%b lat=%0d want 00000078 0 8", d, ng, lat); end
    endtask

    task automatic test_sweep;
        int lat, bcnt; logic [31:0] d; logic ng, inv, p1, held;
        logic [31:0] a, b, exp_d;
        longint diffv;
        for (int n = 0; n < 24; n++) begin
            a = '0; b = '0;
            for (int i = 0; i < 8; i++) begin
                a[4*i +: 4] = 4'($urandom_range(9, 0));
                b[4*i +: 4] = 4'($urandom_range(9, 0));
            end
            diffv = bcd2int(a) - bcd2int(b);
            exp_d = int2bcd(diffv < 0 ? -diffv : diffv);
            drive_op(a, b, lat, bcnt, d, ng, inv, p1, held);
            n_cmp++;
            if (d !== exp_d || ng !== (diffv < 0) || held !== 1'b1 || inv !== 1'b0) begin
                n_err++;
                $display("FAIL sweep %h-%h: D=%h neg=%b held=%b inv=%b want %h %b 1 0", a, b, d, ng, held, inv, exp_d, diffv < 0);
            end
        end
    endtask

    initial begin
        test_reset;
        test_positive;
        test_negative;
        test_extremes;
        test_invalid;
        test_back_to_back;
        test_abort;
        test_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
